// File: rtl/adder_scheduler_pkg.sv
// Shared types and constants for the byte-serial adder scheduler.
package adder_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NBYTES_DEFAULT = 4;
    localparam int unsigned ID_W           = 1;
    localparam int unsigned BYTE_W         = 8;

endpackage

// File: rtl/adder_scheduler_if.sv
// Request/response bundle between two clients, the scheduler and the result consumer.
interface adder_scheduler_if
    import adder_scheduler_pkg::*;
#(
    parameter int unsigned NBYTES = NBYTES_DEFAULT
);
    localparam int unsigned W = BYTE_W * NBYTES;

    logic            io_req0_valid;
    logic            io_req0_ready;
    logic [W-1:0]    io_req0_a;
    logic [W-1:0]    io_req0_b;
    logic            io_req0_cin;

    logic            io_req1_valid;
    logic            io_req1_ready;
    logic [W-1:0]    io_req1_a;
    logic [W-1:0]    io_req1_b;
    logic            io_req1_cin;

    logic            io_resp_valid;
    logic            io_resp_ready;
    logic [W-1:0]    io_resp_sum;
    logic            io_resp_cout;
    logic [ID_W-1:0] io_resp_id;

    logic            io_busy;

    // Client/consumer side
    modport master (
        output io_req0_valid, io_req0_a, io_req0_b, io_req0_cin,
        output io_req1_valid, io_req1_a, io_req1_b, io_req1_cin,
        output io_resp_ready,
        input  io_req0_ready, io_req1_ready,
        input  io_resp_valid, io_resp_sum, io_resp_cout, io_resp_id, io_busy
    );

    // Scheduler side
    modport slave (
        input  io_req0_valid, io_req0_a, io_req0_b, io_req0_cin,
        input  io_req1_valid, io_req1_a, io_req1_b, io_req1_cin,
        input  io_resp_ready,
        output io_req0_ready, io_req1_ready,
        output io_resp_valid, io_resp_sum, io_resp_cout, io_resp_id, io_busy
    );

endinterface

// File: rtl/adder_scheduler_adder8_cin.sv
// Shared 8-bit adder slice with carry in/out.
module adder8_cin
    import adder_scheduler_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] s,
    output logic              cout
);

    // 9-bit sum split into carry and byte
    assign {cout, s} = (BYTE_W+1)'(a) + (BYTE_W+1)'(b) + (BYTE_W+1)'(cin);

endmodule

// File: rtl/adder_scheduler.sv
// Arbitrates two requesters onto one 8-bit adder and sums their operands LSB byte first.
module adder_scheduler
    import adder_scheduler_pkg::*;
#(
    parameter int unsigned NBYTES = NBYTES_DEFAULT
)(
    input  logic              clock,
    input  logic              reset,
    adder_scheduler_if.slave  io
);

    localparam int unsigned W     = BYTE_W * NBYTES;
    localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    state_t            state_q;
    state_t            state_d;
    logic              rr_q;
    logic [ID_W-1:0]   id_q;
    logic [IDX_W-1:0]  idx_q;
    logic              carry_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [W-1:0]      sum_q;
    logic              resp_valid_q;
    logic              busy_q;

    logic              grant0;
    logic              grant1;
    logic              accept;
    logic [BYTE_W-1:0] byte_a;
    logic [BYTE_W-1:0] byte_b;
    logic [BYTE_W-1:0] byte_s;
    logic              byte_c;

    assign byte_a = a_q[idx_q*BYTE_W +: BYTE_W];
    assign byte_b = b_q[idx_q*BYTE_W +: BYTE_W];
    assign accept = grant0 | grant1;

    adder8_cin u_adder (
        .a    (byte_a),
        .b    (byte_b),
        .cin  (carry_q),
        .s    (byte_s),
        .cout (byte_c)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and round-robin grant; rr_q=1 gives requester 1 priority
    always_comb begin
        state_d = state_q;
        grant0  = 1'b0;
        grant1  = 1'b0;
        case (state_q)
            IDLE: begin
                grant0 = io.io_req0_valid && (!io.io_req1_valid || !rr_q);
                grant1 = io.io_req1_valid && (!io.io_req0_valid ||  rr_q);
                if (grant0 || grant1) state_d = RUN;
            end
            RUN:     if (idx_q == IDX_LAST) state_d = DONE;
            DONE:    if (io.io_resp_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, byte-serial accumulation and response flops
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_q         <= 1'b0;
            id_q         <= '0;
            idx_q        <= '0;
            carry_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= grant1 ? io.io_req1_a   : io.io_req0_a;
                b_q     <= grant1 ? io.io_req1_b   : io.io_req0_b;
                carry_q <= grant1 ? io.io_req1_cin : io.io_req0_cin;
                idx_q   <= '0;
                id_q    <= ID_W'(grant1);
                rr_q    <= ~grant1;
            end
            if (state_q == RUN) begin
                sum_q[idx_q*BYTE_W +: BYTE_W] <= byte_s;
                carry_q                       <= byte_c;
                if (idx_q != IDX_LAST) idx_q <= idx_q + IDX_W'(1);
            end
            resp_valid_q <= (state_d == DONE);
            busy_q       <= (state_d != IDLE);
        end
    end

    assign io.io_req0_ready = grant0;
    assign io.io_req1_ready = grant1;
    assign io.io_resp_valid = resp_valid_q;
    assign io.io_resp_sum   = sum_q;
    assign io.io_resp_cout  = carry_q;
    assign io.io_resp_id    = id_q;
    assign io.io_busy       = busy_q;

endmodule

// File: tb/tb_adder_scheduler.sv
// Directed bench for adder_scheduler with NBYTES=4.
module tb_adder_scheduler;
    import adder_scheduler_pkg::*;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;

    logic clock = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    adder_scheduler_if #(.NBYTES(NB)) io ();

    adder_scheduler #(.NBYTES(NB)) dut (
        .clock (clock),
        .reset (reset),
        .io    (io)
    );

    task automatic idle_bus();
        io.io_req0_valid = 1'b0; io.io_req0_a = '0; io.io_req0_b = '0; io.io_req0_cin = 1'b0;
        io.io_req1_valid = 1'b0; io.io_req1_a = '0; io.io_req1_b = '0; io.io_req1_cin = 1'b0;
        io.io_resp_ready = 1'b0;
    endtask

    task automatic drive_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        if (r == 0) begin
            io.io_req0_valid = 1'b1; io.io_req0_a = a; io.io_req0_b = b; io.io_req0_cin = cin;
        end else begin
            io.io_req1_valid = 1'b1; io.io_req1_a = a; io.io_req1_b = b; io.io_req1_cin = cin;
        end
    endtask

    // Called at the negedge after the accepting edge; lat = edges since accept
    task automatic wait_resp(output int lat);
        lat = 0;
        while (!io.io_resp_valid && lat < 50) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic finish_resp();
        io.io_resp_ready = 1'b1;
        @(negedge clock);
        io.io_resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_bus();
        reset = 1'b0;
        @(negedge clock);
        if (io.io_resp_valid !== 1'b0) begin $display("FAIL rst_resp_valid got %b exp 0", io.io_resp_valid); miscompares++; end
        vectors++;
        if (io.io_resp_sum !== 32'h0) begin $display("FAIL rst_sum got %h exp 00000000", io.io_resp_sum); miscompares++; end
        vectors++;
        if (io.io_resp_cout !== 1'b0 || io.io_resp_id !== 1'b0) begin
            $display("FAIL rst_cout_id got %b/%b exp 0/0", io.io_resp_cout, io.io_resp_id); miscompares++;
        end
        vectors++;
        if (io.io_busy !== 1'b0) begin $display("FAIL rst_busy got %b exp 0", io.io_busy); miscompares++; end
        vectors++;
        if (io.io_req0_ready !== 1'b0 || io.io_req1_ready !== 1'b0) begin
            $display("FAIL rst_ready_novalid got %b%b exp 00", io.io_req0_ready, io.io_req1_ready); miscompares++;
        end
        vectors++;
        io.io_req1_valid = 1'b1;
        #1;
        if (io.io_req1_ready !== 1'b1 || io.io_req0_ready !== 1'b0) begin
            $display("FAIL rst_ready_arb got r0=%b r1=%b exp r0=0 r1=1", io.io_req0_ready, io.io_req1_ready); miscompares++;
        end
        vectors++;
        io.io_req1_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_single_add();
        int lat;
        @(negedge clock);
        drive_req(0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        #1;
        if (io.io_req0_ready !== 1'b1 || io.io_req1_ready !== 1'b0) begin
            $display("FAIL single_ready got r0=%b r1=%b exp r0=1 r1=0", io.io_req0_ready, io.io_req1_ready); miscompares++;
        end
        vectors++;
        @(negedge clock);
        idle_bus();
        wait_resp(lat);
        if (lat != 4) begin $display("FAIL single_latency got %0d exp 4", lat); miscompares++; end
        vectors++;
        if (io.io_resp_sum !== 32'h0000_0100 || io.io_resp_cout !== 1'b0 || io.io_resp_id !== 1'b0) begin
            $display("FAIL single_result got %h/%b/%b exp 00000100/0/0", io.io_resp_sum, io.io_resp_cout, io.io_resp_id);
            miscompares++;
        end
        vectors++;
        finish_resp();
        #1;
        if (io.io_resp_valid !== 1'b0 || io.io_busy !== 1'b0) begin
            $display("FAIL single_release got valid=%b busy=%b exp 0/0", io.io_resp_valid, io.io_busy); miscompares++;
        end
        vectors++;
    endtask

    task automatic test_carry_in();
        int lat;
        @(negedge clock);
        drive_req(1, 32'h1234_5678, 32'h0000_000F, 1'b1);
        #1;
        if (io.io_req1_ready !== 1'b1 || io.io_req0_ready !== 1'b0) begin
            $display("FAIL cin_ready got r0=%b r1=%b exp r0=0 r1=1", io.io_req0_ready, io.io_req1_ready); miscompares++;
        end
        vectors++;
        @(negedge clock);
        idle_bus();
        wait_resp(lat);
        if (lat != 4) begin $display("FAIL cin_latency got %0d exp 4", lat); miscompares++; end
        vectors++;
        if (io.io_resp_sum !== 32'h1234_5688 || io.io_resp_cout !== 1'b0 || io.io_resp_id !== 1'b1) begin
            $display("FAIL cin_result got %h/%b/%b exp 12345688/0/1", io.io_resp_sum, io.io_resp_cout, io.io_resp_id);
            miscompares++;
        end
        vectors++;
        finish_resp();
    endtask

    task automatic test_overflow();
        int lat;
        @(negedge clock);
        drive_req(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        @(negedge clock);
        idle_bus();
        wait_resp(lat);
        if (io.io_resp_sum !== 32'h0000_0000 || io.io_resp_cout !== 1'b1) begin
            $display("FAIL ovf_wrap got %h/%b exp 00000000/1", io.io_resp_sum, io.io_resp_cout); miscompares++;
        end
        vectors++;
        finish_resp();
        drive_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        @(negedge clock);
        idle_bus();
        wait_resp(lat);
        if (lat != 4) begin $display("FAIL ovf_latency got %0d exp 4", lat); miscompares++; end
        vectors++;
        if (io.io_resp_sum !== 32'hFFFF_FFFF || io.io_resp_cout !== 1'b1) begin
            $display("FAIL ovf_max got %h/%b exp FFFFFFFF/1", io.io_resp_sum, io.io_resp_cout); miscompares++;
        end
        vectors++;
        finish_resp();
    endtask

    task automatic test_contention();
        int g_cyc[4];
        int g_who[4];
        int r_id[4];
        logic [W-1:0] r_sum[4];
        int ng = 0;
        int nr = 0;
        int both = 0;
        @(negedge clock);
        reset = 1'b0;
        idle_bus();
        drive_req(0, 32'h0000_0001, 32'h0000_0002, 1'b0);
        drive_req(1, 32'h0000_0100, 32'h0000_0005, 1'b1);
        io.io_resp_ready = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (io.io_req0_ready && io.io_req1_ready) both++;
            if ((io.io_req0_ready || io.io_req1_ready) && ng < 4) begin
                g_cyc[ng] = c;
                g_who[ng] = io.io_req1_ready ? 1 : 0;
                ng++;
            end
            if (io.io_resp_valid && nr < 4) begin
                r_id[nr]  = int'(io.io_resp_id);
                r_sum[nr] = io.io_resp_sum;
                nr++;
            end
            @(negedge clock);
        end
        idle_bus();
        if (both != 0) begin $display("FAIL cont_dual_ready got %0d cycles exp 0", both); miscompares++; end
        vectors++;
        if (ng != 4 || nr != 4) begin $display("FAIL cont_counts got grants=%0d resps=%0d exp 4/4", ng, nr); miscompares++; end
        vectors++;
        for (int i = 0; i < ng; i++) begin
            if (g_cyc[i] != 6 * i || g_who[i] != (i % 2)) begin
                $display("FAIL cont_grant%0d got cyc=%0d who=%0d exp cyc=%0d who=%0d", i, g_cyc[i], g_who[i], 6 * i, i % 2);
                miscompares++;
            end
            vectors++;
        end
        for (int i = 0; i < nr; i++) begin
            if (r_id[i] != (i % 2) || r_sum[i] !== ((i % 2 == 1) ? 32'h0000_0106 : 32'h0000_0003)) begin
                $display("FAIL cont_resp%0d got id=%0d sum=%h exp id=%0d sum=%h", i, r_id[i], r_sum[i], i % 2,
                         (i % 2 == 1) ? 32'h0000_0106 : 32'h0000_0003);
                miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        drive_req(1, 32'h0000_00F0, 32'h0000_0010, 1'b0);
        @(negedge clock);
        idle_bus();
        wait_resp(lat);
        drive_req(0, 32'h0102_0304, 32'h1020_3040, 1'b0);
        drive_req(1, 32'h5555_5555, 32'h1111_1111, 1'b0);
        for (int c = 0; c < 10; c++) begin
            #1;
            if (io.io_resp_valid !== 1'b1 || io.io_resp_sum !== 32'h0000_0100 || io.io_resp_cout !== 1'b0 ||
                io.io_resp_id !== 1'b1 || io.io_req0_ready !== 1'b0 || io.io_req1_ready !== 1'b0 || io.io_busy !== 1'b1) begin
                $display("FAIL bp_hold cyc%0d got v=%b sum=%h c=%b id=%b rdy=%b%b busy=%b exp 1/00000100/0/1/00/1", c,
                         io.io_resp_valid, io.io_resp_sum, io.io_resp_cout, io.io_resp_id,
                         io.io_req0_ready, io.io_req1_ready, io.io_busy);
                bad++;
            end
            @(negedge clock);
        end
        if (bad != 0) miscompares++;
        vectors++;
        io.io_resp_ready = 1'b1;
        @(negedge clock);
        io.io_resp_ready = 1'b0;
        #1;
        if (io.io_resp_valid !== 1'b0 || io.io_busy !== 1'b0 || io.io_req0_ready !== 1'b1 || io.io_req1_ready !== 1'b0) begin
            $display("FAIL bp_release got v=%b busy=%b r0=%b r1=%b exp 0/0/1/0",
                     io.io_resp_valid, io.io_busy, io.io_req0_ready, io.io_req1_ready);
            miscompares++;
        end
        vectors++;
        @(negedge clock);
        idle_bus();
        #1;
        if (io.io_busy !== 1'b1) begin $display("FAIL bp_next_accept got busy=%b exp 1", io.io_busy); miscompares++; end
        vectors++;
        wait_resp(lat);
        if (lat != 4 || io.io_resp_sum !== 32'h1122_3344 || io.io_resp_id !== 1'b0) begin
            $display("FAIL bp_next_result got lat=%0d sum=%h id=%b exp 4/11223344/0", lat, io.io_resp_sum, io.io_resp_id);
            miscompares++;
        end
        vectors++;
        finish_resp();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        drive_req(1, 32'h1111_1111, 32'h2222_2222, 1'b0);
        @(negedge clock);
        idle_bus();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        if (io.io_resp_valid !== 1'b0 || io.io_busy !== 1'b0) begin
            $display("FAIL midrst_flags got v=%b busy=%b exp 0/0", io.io_resp_valid, io.io_busy); miscompares++;
        end
        vectors++;
        if (io.io_resp_sum !== 32'h0 || io.io_resp_cout !== 1'b0 || io.io_resp_id !== 1'b0) begin
            $display("FAIL midrst_clear got %h/%b/%b exp 00000000/0/0", io.io_resp_sum, io.io_resp_cout, io.io_resp_id);
            miscompares++;
        end
        vectors++;
        drive_req(0, 32'hFFFF_0000, 32'h0001_FFFF, 1'b1);
        drive_req(1, 32'h0000_0001, 32'h0000_0001, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        if (io.io_req0_ready !== 1'b1 || io.io_req1_ready !== 1'b0) begin
            $display("FAIL midrst_grant got r0=%b r1=%b exp 1/0", io.io_req0_ready, io.io_req1_ready); miscompares++;
        end
        vectors++;
        @(negedge clock);
        idle_bus();
        wait_resp(lat);
        if (lat != 4 || io.io_resp_sum !== 32'h0001_0000 || io.io_resp_cout !== 1'b1 || io.io_resp_id !== 1'b0) begin
            $display("FAIL midrst_result got lat=%0d %h/%b/%b exp 4/00010000/1/0",
                     lat, io.io_resp_sum, io.io_resp_cout, io.io_resp_id);
            miscompares++;
        end
        vectors++;
        finish_resp();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_carry_in();
        test_overflow();
        test_contention();
        test_backpressure();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adder_scheduler.md
# adder_scheduler

Shares one 8-bit carry-chained adder between two requesters and sequences multi-byte additions over it byte-serially, least-significant byte first. Each request carries two NBYTES-byte operands and a carry-in. The block returns the full sum, carry-out and requester id through a valid/ready response port. It sits between client logic and the 8-bit add datapath, and replaces per-client wide adders.

## Interface
- NBYTES, 4: operand width in bytes, ≥2; operand width W = 8*NBYTES.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- io_req0_valid  in  1  requester 0 has a request.
- io_req0_ready  out  1  requester 0 request accepted this cycle.
- io_req0_a, io_req0_b  in  W  requester 0 operands.
- io_req0_cin  in  1  requester 0 carry-in.
- io_req1_valid / io_req1_ready / io_req1_a / io_req1_b / io_req1_cin: same as requester 0, for requester 1.
- io_resp_valid  out  1  result available.
- io_resp_ready  in  1  consumer takes result.
- io_resp_sum  out  W  (a + b + cin) mod 2^W.
- io_resp_cout  out  1  bit W of a + b + cin.
- io_resp_id  out  1  requester that issued the result.
- io_busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE**
  - The arbiter picks one valid requester. If only one is valid, it wins.
  - If both are valid, the requester selected by the round-robin pointer `rr` wins. `rr` resets to 0 (requester 0 has priority).
  - The winner's ready is asserted combinationally in the same cycle. The loser's ready stays 0.
  - On the accepting edge:
    - capture a, b and cin into internal registers;
    - set byte index idx = 0 and carry = cin;
    - latch id = winner and set rr = ~winner;
    - go to RUN.
  - If neither requester is valid, stay in IDLE.
- **RUN**, once per cycle:
  - {c, s} = a[idx] + b[idx] + carry (9-bit result);
  - sum[idx] ← s and carry ← c;
  - if idx == NBYTES-1, go to DONE; otherwise idx increments.
- **DONE**
  - io_resp_valid = 1.
  - io_resp_sum, io_resp_cout and io_resp_id hold stable until the handshake.
  - On io_resp_valid && io_resp_ready, go to IDLE.
- io_req0_ready and io_req1_ready are 0 in RUN and DONE.
- Request-bus changes after acceptance are ignored.
- Reset asserted in any state aborts the operation:
  - no response is issued;
  - state returns to IDLE and rr returns to 0;
  - result, carry, idx and id registers clear to 0.
- Reset values of outputs:
  - io_req0_ready and io_req1_ready reflect arbitration of valids in IDLE (0 when no valid);
  - io_resp_valid = 0, io_resp_sum = 0, io_resp_cout = 0, io_resp_id = 0, io_busy = 0.

## Timing
- Latency: io_resp_valid rises exactly NBYTES cycles after the accepting edge.
- There is no accept in the cycle in which the response completes. The next accept occurs at the earliest in the cycle after the response handshake.
- Peak throughput: one operation every NBYTES+2 cycles.
- The response port is a registered output: io_resp_* are driven from flops, with no combinational path from io_req*.
- io_req*_ready depends combinationally on io_req*_valid, state and rr only. It never depends on io_resp_ready.
- A requester may hold valid indefinitely. Under continuous contention, grants strictly alternate.

## Structure
- Shared package contents:
  - the state enum (IDLE/RUN/DONE);
  - the default NBYTES constant;
  - the id width constant (1);
  - the byte width constant (8).
- One sub-module, adder8_cin: inputs a[7:0], b[7:0], cin; outputs s[7:0], cout. It is purely combinational and instantiated once.
- The top level holds:
  - the FSM;
  - the round-robin arbiter;
  - operand/result shift or index registers;
  - the carry flop.

## Test plan
- **Single add:** NBYTES=4; req0 only, a=0x000000FF, b=0x00000001, cin=0 → req0_ready=1 in the request cycle; resp_valid 4 cycles later; sum=0x00000100, cout=0, id=0.
- **Carry-in:** req1 only, a=0x12345678, b=0x0000000F, cin=1 → sum=0x12345688, cout=0, id=1.
- **Overflow:** a=0xFFFFFFFF, b=0x00000001, cin=0 → sum=0x00000000, cout=1. Also a=0xFFFFFFFF, b=0xFFFFFFFF, cin=1 → sum=0xFFFFFFFF, cout=1.
- **Contention:** both valid from reset and held, resp_ready=1 → ids returned in the order 0,1,0,1. Each accept is 6 cycles apart, and no ready is asserted to the non-granted requester.
- **Backpressure:** resp_ready held 0 for 10 cycles while in DONE → resp_sum/cout/id stable, both readys 0, busy=1. Raising resp_ready → IDLE on the next edge, and the next accept occurs in the following cycle.
- **Reset mid-RUN:** assert reset after 2 RUN cycles → resp_valid=0 and busy=0 immediately. After release with both requesters valid, req0 is granted and the correct sum is produced.
